serial_sub_ctrl: RTL and testbench
==================================

// Module: serial_sub_ctrl
// PURPOSE
//  Bit-serial subtractor controller: computes a - b over WIDTH bits, LSB first.
//  Datapath per bit is two half-subtractor cells plus a borrow OR (a full subtractor).
//  Shares one 1-bit subtract cell across all bit positions, sequenced by a
//  counter and a 3-state FSM with a start/busy/done handshake.
//  Sits between a requester (ALU/testbench host) and the 1-bit subtract datapath.
// PARAMETERS
//  WIDTH    8   operand/result width in bits; legal range >= 1
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous, active-low reset
//  start       in   1      request; sampled only in IDLE
//  a           in   WIDTH  minuend, captured on the accept edge
//  b           in   WIDTH  subtrahend, captured on the accept edge
//  busy        out  1      high in RUN and DONE
//  done        out  1      one-cycle pulse; result valid
//  diff        out  WIDTH  a - b mod 2^WIDTH; held until the next done
//  borrow_out  out  1      final borrow (1 when a < b unsigned); held with diff
//  ovf         out  1      signed overflow; present only with SERIAL_SUB_OVF_EN
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; busy, done, diff, borrow_out, ovf = 0;
//   internal shift regs, borrow FF and counter cleared.
//  Mid-operation reset: aborts at once; no done is produced; outputs read 0.
//  FSM: IDLE -> RUN on an edge with start=1. RUN -> DONE on the WIDTH-th RUN
//   edge. DONE -> IDLE unconditionally on the next edge.
//  Accept edge E0: a_sh<=a, b_sh<=b, br<=0, cnt<=0. Operands are sampled
//   only at E0; a/b changes during RUN are ignored.
//  RUN edge k (k=1..WIDTH), using a0=a_sh[0], b0=b_sh[0]:
//   d      = a0 ^ b0 ^ br
//   br_nxt = (~a0 & b0) | (~(a0 ^ b0) & br)
//   res_sh <= {d, res_sh[WIDTH-1:1]}; a_sh and b_sh shift right; cnt <= cnt+1.
//  At edge E0+WIDTH, diff and borrow_out load from the final res_sh/br_nxt.
//  done is high during cycle E0+WIDTH .. E0+WIDTH+1, i.e. exactly one cycle.
//  start is ignored while busy=1; there is no queueing.
//  Earliest next accept is edge E0+WIDTH+2. With start held high, one result
//   is produced every WIDTH+2 cycles.
//  cnt width: $clog2(WIDTH+1). WIDTH=1 gives one RUN cycle.
//  diff/borrow_out change only at the DONE-entry edge. They never show partial
//   results during RUN.
// CONFIGURATION
//  SERIAL_SUB_OVF_EN defined:
//   - port ovf exists.
//   - ovf = (a_msb ^ b_msb) & (a_msb ^ d_msb), taken at RUN edge WIDTH.
//   - ovf loads and holds together with diff.
//  SERIAL_SUB_OVF_EN undefined:
//   - no ovf port and no MSB tracking logic.
//   - all other behaviour is identical.
// TESTING (WIDTH=8)
//  T1: reset, then start with a=100, b=37
//      -> done exactly 8 edges after accept; diff=63, borrow_out=0, ovf=0.
//  T2: a=0x05, b=0x0A
//      -> diff=0xFB, borrow_out=1, ovf=0; busy high for 9 cycles.
//  T3: a=0x80, b=0x01
//      -> diff=0x7F, borrow_out=0, ovf=1 (macro on); a=0,b=0 -> diff=0,borrow=0.
//  T4: start held high for 30 cycles
//      -> accepts at E0, E0+10, E0+20; start pulses during busy are ignored;
//         a/b toggled in RUN do not alter the result.
//  T5: rst_n low 4 cycles after accept
//      -> all outputs 0 asynchronously; no done; the next start computes correctly.
//  T6: WIDTH=1 build, a=0, b=1
//      -> diff=1, borrow_out=1, done 1 edge after accept.

Source files
------------

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b (LSB first) over one shared full-subtractor cell; optional ovf via SERIAL_SUB_OVF_EN.
// Latency: done pulses WIDTH cycles after the accept edge; next accept no earlier than WIDTH+2.
// Backpressure: start is only sampled in IDLE, ignored while busy, never queued.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] ar_sh;
  logic [WIDTH-1:0] b_sh;
  logic             br;
  logic [CW-1:0]    cnt;

  logic a0, b0;
  logic hs1_d, hs1_b;
  logic d, hs2_b;
  logic br_nxt;
  logic last_bit;
  logic [WIDTH-1:0] ar_nxt;

  assign a0 = ar_sh[0];
  assign b0 = b_sh[0];

  // Two half-subtractor cells plus a borrow OR form the shared full subtractor.
  assign hs1_d  = a0 ^ b0;
  assign hs1_b  = ~a0 & b0;
  assign d      = hs1_d ^ br;
  assign hs2_b  = ~hs1_d & br;
  assign br_nxt = hs1_b | hs2_b;

  assign last_bit = (cnt == CW'(WIDTH - 1));

  // Minuend bits leave at the LSB while difference bits enter at the MSB, so
  // after WIDTH shifts this register holds the full result.
  generate
    if (WIDTH == 1) begin : g_w1
      assign ar_nxt = d;
    end else begin : g_wn
      assign ar_nxt = {d, ar_sh[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ar_sh      <= '0;
      b_sh       <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            ar_sh <= a;
            b_sh  <= b;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          ar_sh <= ar_nxt;
          b_sh  <= b_sh >> 1;
          br    <= br_nxt;
          cnt   <= cnt + CW'(1);
          if (last_bit) begin
            state      <= DONE;
            done       <= 1'b1;
            diff       <= ar_nxt;
            borrow_out <= br_nxt;
`ifdef SERIAL_SUB_OVF_EN
            // On the last bit a0/b0 are the operand sign bits and d is the result sign.
            ovf        <= (a0 ^ b0) & (a0 ^ d);
`endif
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl: timeline reference model compared every cycle,
// plus directed literal cases and a WIDTH=1 instance.
module tb_serial_sub_ctrl;
  localparam int W = 8;
`ifdef SERIAL_SUB_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, borrow_out;
  logic [W-1:0] diff;
  logic         ovf_v;

  logic         start1 = 1'b0;
  logic [0:0]   a1 = '0;
  logic [0:0]   b1 = '0;
  logic         busy1, done1, bor1;
  logic [0:0]   diff1;
  logic         ovf1_v;

`ifdef SERIAL_SUB_OVF_EN
  logic ovf, ovf1;
  assign ovf_v  = ovf;
  assign ovf1_v = ovf1;
`else
  assign ovf_v  = 1'b0;
  assign ovf1_v = 1'b0;
`endif

  serial_sub_ctrl #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_sub_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bor1)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf1)
`endif
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit sub_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    int r;
    r = int'($signed(x)) - int'($signed(y));
    return (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
  endfunction

  // Reference model: an operation is a timeline counted from its accept edge.
  bit           m_active = 1'b0;
  int           m_t = 0;
  logic [W-1:0] e_diff;
  bit           e_bor, e_ovf;
  logic         m_busy = 1'b0, m_done = 1'b0, m_bor = 1'b0, m_ovf = 1'b0;
  logic [W-1:0] m_diff = '0;
  bit           chk_en = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_active = 1'b0; m_busy = 1'b0; m_done = 1'b0;
      m_diff = '0; m_bor = 1'b0; m_ovf = 1'b0;
    end else if (!m_active) begin
      m_done = 1'b0;
      if (start) begin
        m_active = 1'b1;
        m_t      = 0;
        m_busy   = 1'b1;
        e_diff   = a - b;
        e_bor    = (a < b);
        e_ovf    = sub_ovf(a, b);
      end
    end else begin
      m_t++;
      if (m_t == W) begin
        m_done = 1'b1; m_diff = e_diff; m_bor = e_bor; m_ovf = e_ovf;
      end else if (m_t == W + 1) begin
        m_done = 1'b0; m_busy = 1'b0; m_active = 1'b0;
      end
    end
    chk_en = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en)
      check("cycle {busy,done,borrow,ovf,diff}",
            32'({busy, done, borrow_out, ovf_v, diff}),
            32'({m_busy, m_done, m_bor, OVF_ON & m_ovf, m_diff}));
  end

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ed, input bit eb, input bit eo, input string nm);
    int lat, bc;
    logic [W-1:0] gd;
    bit gb, go;
    lat = -1; gd = '0; gb = 1'b0; go = 1'b0;
    @(negedge clk); #1 start = 1'b1; a = av; b = bv;
    @(negedge clk); #1 start = 1'b0; a = W'($urandom); b = W'($urandom);
    bc = busy ? 1 : 0;
    for (int i = 1; i <= W + 4; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done && lat < 0) begin
        lat = i; gd = diff; gb = borrow_out; go = ovf_v;
      end
      #1 a = W'($urandom); b = W'($urandom);
    end
    check({nm, " latency"}, 32'(lat), 32'(W));
    check({nm, " diff"}, 32'(gd), 32'(ed));
    check({nm, " borrow"}, 32'(gb), 32'(eb));
    if (OVF_ON) check({nm, " ovf"}, 32'(go), 32'(eo));
    check({nm, " busy cycles"}, 32'(bc), 32'(W + 1));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return W'(1) << (W - 1);
      3: return ~(W'(1) << (W - 1));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int dq[$];
    int ndone;
    repeat (3) @(negedge clk);
    check("reset outputs", 32'({busy, done, borrow_out, ovf_v, diff}), 32'(0));
    #1 rst_n = 1'b1;

    // T1..T3 with hand-computed results
    run_op(8'd100, 8'd37, 8'd63, 1'b0, 1'b0, "T1");
    run_op(8'h05, 8'h0A, 8'hFB, 1'b1, 1'b0, "T2");
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "T3a");
    run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, "T3b");
    run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, "T3c");

    // T4: start held for 30 cycles with operands toggling
    @(negedge clk); #1 start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      a = W'($urandom); b = W'($urandom);
      @(negedge clk);
      if (done) dq.push_back(i);
      #1;
    end
    start = 1'b0;
    repeat (W + 4) @(negedge clk);
    check("T4 result count", 32'(dq.size()), 32'd3);
    if (dq.size() == 3) begin
      check("T4 done0", 32'(dq[0]), 32'd8);
      check("T4 done1", 32'(dq[1]), 32'd18);
      check("T4 done2", 32'(dq[2]), 32'd28);
    end

    // T5: reset mid-operation
    run_op(8'd100, 8'd37, 8'd63, 1'b0, 1'b0, "T5 pre");
    @(negedge clk); #1 start = 1'b1; a = 8'h33; b = 8'h11;
    @(negedge clk); #1 start = 1'b0;
    repeat (3) @(negedge clk);
    check("T5 busy before reset", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1 check("T5 async clear", 32'({busy, done, borrow_out, ovf_v, diff}), 32'(0));
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("T5 no done after abort", 32'(ndone), 32'd0);
    run_op(8'hC8, 8'h19, 8'hAF, 1'b0, 1'b0, "T5 post");

    // T6: WIDTH=1 instance
    @(negedge clk); #1 start1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
    @(negedge clk); #1 start1 = 1'b0;
    check("T6 busy/done after accept", 32'({busy1, done1}), 32'b10);
    @(negedge clk);
    check("T6 done/diff/borrow", 32'({done1, diff1, bor1}), 32'b111);
    if (OVF_ON) check("T6 ovf", 32'(ovf1_v), 32'd1);
    @(negedge clk);
    check("T6 idle", 32'({busy1, done1}), 32'b00);

    // Randomized traffic with occasional mid-operation resets
    for (int n = 0; n < 40; n++) begin
      int hold;
      hold = $urandom_range(1, 14);
      @(negedge clk); #1 start = 1'b1; a = pick(); b = pick();
      for (int h = 1; h < hold; h++) begin
        @(negedge clk); #1 a = pick(); b = pick();
      end
      @(negedge clk); #1 start = 1'b0;
      if ($urandom_range(0, 9) == 0) begin
        rst_n = 1'b0;
        @(negedge clk); #1 rst_n = 1'b1;
      end
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    repeat (W + 4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
